// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath select codes for the multicycle RV32I controller.
// The TRAP state exists only when MCU_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI
`ifdef MCU_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALU_MODE_ADD,
        ALU_MODE_SUB,
        ALU_MODE_FUNCT
    } alu_mode_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation select: fixed add/sub for address and compare work, funct3-driven in the execute states.
module mc_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    input  alu_mode_t  mode,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (mode)
            ALU_MODE_SUB: alu_control = ALU_SUB;
            ALU_MODE_FUNCT: begin
                case (funct3)
                    // funct7[5] selects sub only for register-register ops; addi ignores it
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle RV32I datapath with MEM_LAT memory wait states.
// Define MCU_ILLEGAL_TRAP_EN to lock into TRAP (illegal=1) on an unknown opcode.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC on last wait cycle
// DECODE   | compute branch target OldPC+imm, dispatch on opcode
// MEMADR   | compute load/store address RD1+imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory at ALUOut
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BRANCH   | compare RD1-RD2, load target on beq/bne taken
// JAL      | PC <- target, link OldPC+4
// LUI      | write ImmExt to register file
// TRAP     | illegal opcode, parked until reset (feature build only)
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_wait;
    logic             cnt_done;
    logic             pc_update;
    logic             branch;
    logic             mem_write_raw;
    logic             ir_write_raw;
    logic             reg_write_raw;
    alu_mode_t        alu_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter only runs in memory states and is zero on entry to each of them.
    always_comb begin
        mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        cnt_done = (cnt == CNT_W'(MEM_LAT));
        cnt_nxt  = (mem_wait && !cnt_done) ? cnt + 1'b1 : '0;
    end

    always_comb begin
        state_nxt     = state;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_mode      = ALU_MODE_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (cnt_done) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_BR:        state_nxt = S_BRANCH;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_LUI:       state_nxt = S_LUI;
`ifdef MCU_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (cnt_done) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                if (cnt_done) state_nxt = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RD1;
                alu_mode  = ALU_MODE_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                alu_mode  = ALU_MODE_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                alu_mode  = ALU_MODE_SUB;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_LUI: begin
                ResultSrc     = RES_IMMEXT;
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // funct3[0] distinguishes bne from beq, so it inverts the sense of Zero.
    always_comb begin
        PCWrite  = (pc_update | (branch & (Zero ^ funct3[0]))) & ~reset;
        MemWrite = mem_write_raw & ~reset;
        IRWrite  = ir_write_raw & ~reset;
        RegWrite = reg_write_raw & ~reset;
        ImmSrc   = imm_sel(op);
    end

`ifdef MCU_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP) & ~reset;
`else
    assign illegal = 1'b0;
`endif

    mc_alu_decoder u_alu_dec (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op5         (op[5]),
        .mode        (alu_mode),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected output vectors queued per instruction.
// Two instances (MEM_LAT=0 and MEM_LAT=2); the idle one is held in reset.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset0, reset2;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    bit         sel;

    logic       pcw0, adr0, mw0, irw0, rw0, ill0;
    logic [1:0] rs0, sa0, sb0;
    logic [2:0] imm0, alu0;
    logic       pcw2, adr2, mw2, irw2, rw2, ill2;
    logic [1:0] rs2, sa2, sb2;
    logic [2:0] imm2, alu2;

    logic [17:0] exp_q[$];
    logic [2:0]  exp_imm;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_LAT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset0), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(zero),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
        .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0), .ALUControl(alu0),
        .illegal(ill0)
    );

    multicycle_control_unit #(.MEM_LAT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset(reset2), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(zero),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2),
        .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2), .ALUControl(alu2),
        .illegal(ill2)
    );

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal}
    wire [17:0] obs0 = {pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0, imm0, alu0, ill0};
    wire [17:0] obs2 = {pcw2, adr2, mw2, irw2, rw2, rs2, sa2, sb2, imm2, alu2, ill2};

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic put(input bit pcw, input bit adr, input bit mw, input bit irw, input bit rw,
                       input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                       input logic [2:0] alu, input bit ill);
        exp_q.push_back({pcw, adr, mw, irw, rw, rs, a, b, exp_imm, alu, ill});
    endtask

    task automatic put_fetch(input int lat);
        for (int i = 0; i <= lat; i++)
            put(i == lat, 0, 0, i == lat, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    endtask

    task automatic put_decode();
        put(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    endtask

    task automatic put_aluwb();
        put(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endtask

    // One queued vector per cycle; sampled 1 time unit after the falling edge.
    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            chk($sformatf("%s c%0d", name, cyc), sel ? obs2 : obs0, exp_q.pop_front());
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
        zero     = z;
        exp_imm  = imm_of(o);
    endtask

    // Issue one instruction from FETCH and queue its expected cycle-by-cycle outputs.
    task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int lat, input logic [2:0] alu, input bit taken);
        drive(o, f3, f7, z);
        put_fetch(lat);
        put_decode();
        case (o)
            7'b0110011: begin
                put(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0);
                put_aluwb();
            end
            7'b0010011: begin
                put(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0);
                put_aluwb();
            end
            7'b0000011: begin
                put(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
                for (int i = 0; i <= lat; i++) put(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
                put(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
            end
            7'b0100011: begin
                put(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
                for (int i = 0; i <= lat; i++) put(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
            end
            7'b1100011: put(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
            7'b1101111: begin
                put(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
                put_aluwb();
            end
            7'b0110111: put(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 0);
            default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) put(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
`endif
            end
        endcase
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1);
    end

    initial begin
        reset0 = 1'b1;
        reset2 = 1'b1;
        sel    = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        // Second reset cycle: FETCH selects visible, enables forced low.
        put(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        drain("reset");
        reset0 = 1'b0;

        run("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, 3'b000, 0);
        run("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 0, 3'b001, 0);
        run("addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 3'b000, 0);
        run("xori",  7'b0010011, 3'b100, 1'b0, 1'b0, 0, 3'b100, 0);
        run("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 0, 3'b011, 0);
        run("and",   7'b0110011, 3'b111, 1'b1, 1'b0, 0, 3'b010, 0);
        run("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 0, 3'b101, 0);
        run("sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 0, 3'b000, 0);
        run("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 3'b001, 1);
        run("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 3'b001, 0);
        run("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 3'b001, 0);
        run("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 0, 3'b001, 1);
        run("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 0, 3'b000, 0);
        run("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 0, 3'b000, 0);
        run("lw0",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3'b000, 0);
        run("sw0",   7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3'b000, 0);

        run("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 3'b000, 0);
`ifdef MCU_ILLEGAL_TRAP_EN
        // Reset cycle while trapped clears illegal, then FETCH under reset.
        reset0 = 1'b1;
        put(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        put(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        drain("trap_rst");
        reset0 = 1'b0;
`endif
        run("after_ill", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 3'b000, 0);

        // Switch to the MEM_LAT=2 instance.
        reset0 = 1'b1;
        sel    = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        run("lw2",  7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3'b000, 0);
        run("sw2",  7'b0100011, 3'b010, 1'b0, 1'b0, 2, 3'b000, 0);
        run("add2", 7'b0110011, 3'b000, 1'b0, 1'b0, 2, 3'b000, 0);
        run("bne2", 7'b1100011, 3'b001, 1'b0, 1'b0, 2, 3'b001, 1);

        // lw interrupted by reset in the second MEMREAD wait cycle.
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        put_fetch(2);
        put_decode();
        put(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        put(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        drain("lw_pre");
        reset2 = 1'b1;
        put(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        put(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        drain("lw_rst");
        reset2 = 1'b0;
        run("lw_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3'b000, 0);

        chk("queue_empty", 18'(exp_q.size()), 18'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control unit for the multicycle RV32I datapath; successor to the single-cycle controller.
- A Moore FSM sequences fetch, decode, execute, memory access and writeback over several cycles, sharing one ALU and one unified memory.
- Adds a parametrised memory wait-state counter, bne support, jal and lui.

Parameters:
MEM_LAT, 0, extra wait cycles per memory access (0..15); applies in FETCH, MEMREAD and MEMWRITE.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
op  in  7  opcode from the instruction register
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register and OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 100 = xor, 101 = slt
illegal  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset: state <= FETCH, wait counter <= 0.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0.
  - Reset taken mid-instruction abandons it; no enable pulses in the reset cycle.
- Outputs are combinational decodes of the state register (Moore), except:
  - PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])).
  - ALUControl in EXECUTER/EXECUTEI, decoded from funct3.
- Outputs not listed for a state are 0. ImmSrc is decoded from op in every state.
- Wait states in FETCH, MEMREAD and MEMWRITE:
  - Counter runs 0..MEM_LAT; the state holds until the count reaches MEM_LAT.
  - IRWrite and PCUpdate assert only on the final cycle. MemWrite is held for all MEM_LAT+1 cycles.
  - Counter clears on every state exit.
- States (outputs -> next state):
  - FETCH: AdrSrc=0, IRWrite, A=00, B=10, add, ResultSrc=10, PCUpdate -> DECODE
  - DECODE: A=01, B=01, add (branch target) -> by op:
    - lw/sw (0000011, 0100011) -> MEMADR
    - R-type 0110011 -> EXECUTER
    - I-ALU 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - otherwise -> FETCH, or TRAP when the feature is on
  - MEMADR: A=10, B=01, add -> MEMREAD if op[5]=0, else MEMWRITE
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB
  - MEMWB: ResultSrc=01, RegWrite -> FETCH
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite -> FETCH
  - EXECUTER: A=10, B=00, funct -> ALUWB
  - EXECUTEI: A=10, B=01, funct -> ALUWB
  - ALUWB: ResultSrc=00, RegWrite -> FETCH
  - BRANCH: A=10, B=00, sub, ResultSrc=00, Branch -> FETCH
  - JAL: A=01, B=10, add, ResultSrc=00, PCUpdate -> ALUWB
  - LUI: ResultSrc=11, RegWrite -> FETCH
- Funct decode (ALUControl):
  - funct3 000: sub if op[5] & funct7_5 (R-type only), else add.
  - 010 -> slt; 100 -> xor; 110 -> or; 111 -> and; any other funct3 -> add.
- Branch resolution: beq (funct3=000) taken when Zero=1; bne (funct3=001) taken when Zero=0.
- Cycle counts at MEM_LAT=L:
  - lw 5+2L, sw 4+2L, R/I 4+L, branch 3+L, jal 4+L, lui 3+L.

Optional Feature:
MCU_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE -> TRAP. TRAP holds with all enables 0 and illegal=1 until reset.
- Undefined: an unknown opcode returns to FETCH as a no-op; illegal is tied to 0 and the TRAP state does not exist.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants and the state enumeration (4-bit);
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc code constants.
- Sub-module mc_alu_decoder: combinational (funct3, funct7_5, op[5], mode) -> ALUControl. Instantiated once.

Test Plan:
- MEM_LAT=0, reset held 2 cycles, then R-type add (op=0110011, f3=000, f7_5=0):
  - FETCH -> DECODE -> EXECUTER -> ALUWB -> FETCH;
  - IRWrite/PCWrite high in cycle 1, RegWrite high in cycle 4, ALUControl=000 in EXECUTER.
- sub (f7_5=1) -> ALUControl=001. addi with f7_5=1 -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne with Zero=1 -> PCWrite=0. Branch takes 3 cycles.
- MEM_LAT=2, lw:
  - FETCH lasts 3 cycles, IRWrite only on the 3rd;
  - MEMREAD lasts 3 cycles, AdrSrc=1 throughout;
  - total 9 cycles, RegWrite only in MEMWB.
- MEM_LAT=2, sw -> MemWrite high exactly 3 cycles, RegWrite never asserted.
- reset asserted during MEMREAD wait -> next cycle FETCH, counter 0, no RegWrite/MemWrite.
- op=1111111:
  - with MCU_ILLEGAL_TRAP_EN: illegal=1 and held, PCWrite stays 0;
  - without: returns to FETCH after DECODE.
